// File: rtl/cnt_sweep_pkg.sv
// Shared types and widths for the sweep controller.
// Imported by the controller and its bench.
package cnt_sweep_pkg;

  localparam int CNT_W = 16;
  localparam int SWP_W = 8;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SWP_W-1:0] SWP_ONE = SWP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_DONE
  } sweep_state_t;

endpackage

// File: rtl/cnt_sweep_ctrl.sv
// Drives an external up/down counter through N up-then-down sweeps,
// shadowing its value and aborting on any divergence.
module cnt_sweep_ctrl
  import cnt_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] lo_bound,
  input  logic [CNT_W-1:0] hi_bound,
  input  logic [SWP_W-1:0] num_sweeps,
  input  logic [CNT_W-1:0] cnt_value,
  output logic [CNT_W-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  sweep_state_t state, state_nxt;

  logic [CNT_W-1:0] lo_q;
  logic [CNT_W-1:0] hi_q;
  logic [SWP_W-1:0] num_q;
  logic [CNT_W-1:0] exp_q;
  logic [SWP_W-1:0] rem_q;
  logic             err_q;

  logic accept;
  logic mism;
  logic at_top;
  logic at_bot;

  assign accept = start && (lo_bound < hi_bound) && (num_sweeps != '0);
  assign mism   = cnt_value != exp_q;
  assign at_top = exp_q == (hi_q - CNT_ONE);
  assign at_bot = exp_q == (lo_q + CNT_ONE);

  assign data_in = lo_q;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_cnt    = 1'b1;
    updn_cnt  = 1'b0;
    count_enb = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ld_cnt    = 1'b0;
        state_nxt = S_UP;
      end
      S_UP: begin
        count_enb = 1'b1;
        updn_cnt  = 1'b1;
        if (mism) state_nxt = S_IDLE;
        else if (at_top) state_nxt = S_DOWN;
      end
      S_DOWN: begin
        count_enb = 1'b1;
        if (mism) state_nxt = S_IDLE;
        else if (at_bot)
          state_nxt = (rem_q > SWP_ONE) ? S_UP : S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Shadow datapath: bounds, expected count, sweeps left, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q  <= '0;
      hi_q  <= '0;
      num_q <= '0;
      exp_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            lo_q  <= lo_bound;
            hi_q  <= hi_bound;
            num_q <= num_sweeps;
            err_q <= 1'b0;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        S_LOAD: begin
          exp_q <= lo_q;
          rem_q <= num_q;
        end
        S_UP: begin
          if (mism) err_q <= 1'b1;
          else exp_q <= exp_q + CNT_ONE;
        end
        S_DOWN: begin
          if (mism) begin
            err_q <= 1'b1;
          end else begin
            exp_q <= exp_q - CNT_ONE;
            if (at_bot) rem_q <= rem_q - SWP_ONE;
          end
        end
        S_DONE: begin
          if (mism) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Bench for cnt_sweep_ctrl: behavioural up/down counter plus
// an arithmetic per-cycle model of the sweep schedule.
module tb_cnt_sweep_ctrl;
  import cnt_sweep_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] lo_bound = '0;
  logic [15:0] hi_bound = '0;
  logic [7:0]  num_sweeps = '0;
  logic [15:0] cnt_value;
  logic [15:0] data_in;
  logic        ld_cnt, updn_cnt, count_enb;
  logic        busy, done, err;

  logic [15:0] cnt_q;
  logic        flip = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cnt_sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .lo_bound   (lo_bound),
    .hi_bound   (hi_bound),
    .num_sweeps (num_sweeps),
    .cnt_value  (cnt_value),
    .data_in    (data_in),
    .ld_cnt     (ld_cnt),
    .updn_cnt   (updn_cnt),
    .count_enb  (count_enb),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (!ld_cnt) cnt_q <= data_in;
    else if (count_enb)
      cnt_q <= updn_cnt ? cnt_q + 16'd1 : cnt_q - 16'd1;
  end

  assign cnt_value = cnt_q ^ {15'd0, flip};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  function automatic logic [5:0] ctl();
    return {busy, ld_cnt, count_enb, updn_cnt, done, err};
  endfunction

  // ctl order: busy, ld_cnt, count_enb, updn_cnt, done, err
  task automatic run(input logic [15:0] lo,
                     input logic [15:0] hi,
                     input logic [7:0]  n,
                     input int ghost_k,
                     input int fault_k,
                     input int rst_k);
    int d, t, ph;
    logic up;
    logic [5:0] want;
    d = int'(hi) - int'(lo);
    t = 2 + 2 * d * int'(n);
    @(negedge clk);
    lo_bound   = lo;
    hi_bound   = hi;
    num_sweeps = n;
    start      = 1'b1;
    for (int k = 1; k <= t + 1; k++) begin
      @(negedge clk);
      start      = 1'b0;
      lo_bound   = 16'($urandom);
      hi_bound   = 16'($urandom);
      num_sweeps = 8'($urandom);
      if (k == 1) begin
        want = 6'b100000;
      end else if (k < t) begin
        ph   = (k - 2) % (2 * d);
        up   = ph < d;
        want = {3'b111, up, 2'b00};
        chk("cnt", cnt_value, 32'(lo) + 32'(up ? ph : 2 * d - ph));
      end else if (k == t) begin
        want = 6'b110010;
        chk("cnt_done", cnt_value, lo);
      end else begin
        want = 6'b010000;
      end
      chk($sformatf("ctl_k%0d", k), ctl(), want);
      chk("data_in", data_in, lo);
      if (k == ghost_k) start = 1'b1;
      if (k == fault_k) begin
        flip = 1'b1;
        @(negedge clk);
        flip = 1'b0;
        chk("abort_ctl", ctl(), 6'b010001);
        for (int j = k + 2; j <= t + 1; j++) begin
          @(negedge clk);
          chk("abort_nodone", {busy, done}, 2'b00);
        end
        return;
      end
      if (k == rst_k) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ctl", ctl(), 6'b010000);
        chk("rst_data", data_in, 16'd0);
        return;
      end
    end
  endtask

  task automatic bad_start(input logic [15:0] lo,
                           input logic [15:0] hi,
                           input logic [7:0]  n);
    @(negedge clk);
    lo_bound   = lo;
    hi_bound   = hi;
    num_sweeps = n;
    start      = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("bad_ctl", ctl(), 6'b010001);
    end
  endtask

  initial begin
    int d, n, g;
    logic [15:0] lo;
    lo_bound   = 16'd10;
    hi_bound   = 16'd13;
    num_sweeps = 8'd1;
    start      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctl", ctl(), 6'b010000);
    chk("reset_data", data_in, 16'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", ctl(), 6'b010000);

    run(16'd10, 16'd13, 8'd1, 0, 0, 0);
    run(16'd0, 16'd1, 8'd3, 0, 0, 0);
    run(16'hFFF0, 16'hFFFF, 8'd1, 0, 0, 0);
    bad_start(16'd5, 16'd5, 8'd1);
    bad_start(16'd5, 16'd9, 8'd0);
    bad_start(16'd9, 16'd5, 8'd2);
    run(16'd10, 16'd13, 8'd1, 0, 3, 0);
    run(16'd10, 16'd13, 8'd2, 0, 0, 6);
    run(16'd10, 16'd13, 8'd2, 0, 0, 0);
    run(16'd10, 16'd13, 8'd1, 4, 0, 0);

    for (int i = 0; i < 14; i++) begin
      d  = int'($urandom_range(1, 6));
      n  = int'($urandom_range(1, 3));
      lo = 16'($urandom_range(0, 65000));
      g  = ($urandom % 2 == 0) ? 0 :
           2 + int'($urandom_range(0, 2 * d * n - 1));
      run(lo, lo + 16'(d), 8'(n), g, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
